// File: rtl/apb_req_master_if.sv
// Bundles the request, response and APB initiator signals of apb_req_master.
// The master modport is the controller's view. The slave modport is the
// view of whatever sits around it: the requester, the response consumer
// and the APB target.
interface apb_req_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request channel
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  req_write_i;
    // Response channel
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;
    // APB initiator
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic                  pwrite_o;
    logic                  psel_o;
    logic                  penable_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_write_i,
        input  rsp_ready_i, prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_write_i,
        output rsp_ready_i, prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding request/response to APB initiator bridge.
// It accepts one request, runs the SETUP and ACCESS phases with an optional
// wait-state timeout, and then holds the response until it is consumed.
module apb_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    apb_req_master_if.master  bus
);
    // TIMEOUT=0 would give a zero-width counter. Keep one bit so the code stays legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the wait counter during the ACCESS cycle numbered TIMEOUT.
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // State and datapath registers, with a synchronous reset that abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The APB inputs are sampled only in ACCESS, and completion wins over timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = SETUP;
                    addr_d  = bus.req_addr_i;
                    // Reads put zero on pwdata.
                    wdata_d = bus.req_write_i ? bus.req_wdata_i : '0;
                    write_d = bus.req_write_i;
                    cnt_d   = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : bus.prdata_i;
                    err_d   = bus.pslverr_i;
                    to_d    = 1'b0;
                end else if ((TIMEOUT > 0) && (cnt_q == LIMIT)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o     = (state_q == ACCESS);
    assign bus.rsp_valid_o   = (state_q == RESP);
    assign bus.paddr_o       = addr_q;
    assign bus.pwdata_o      = wdata_q;
    assign bus.pwrite_o      = write_q;
    assign bus.rsp_rdata_o   = rdata_q;
    assign bus.rsp_err_o     = err_q;
    assign bus.rsp_timeout_o = to_q;
endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with TIMEOUT=4. Inputs change and
// outputs are sampled on the falling edge.
module tb_apb_req_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    apb_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Present a request on a falling edge. The task returns on the next
    // falling edge, when the DUT should be in SETUP.
    task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        bus.req_write_i = w;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 32'hFFFF_FFFF;
        bus.req_wdata_i = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.pwrite_o} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b want 000000",
                     {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.pwrite_o});
        end else passed++;
        total++;
        if ({bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o} !== 96'b0) begin
            $display("FAIL reset_data got %h %h %h want 0", bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o);
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready_o);
        else passed++;
    endtask

    task automatic test_read_zero_wait();
        send_req(32'h40, 32'hCAFE_F00D, 1'b0);
        total++;
        if ({bus.req_ready_o, bus.psel_o, bus.penable_o, bus.pwrite_o} !== 4'b0100 ||
            bus.paddr_o !== 32'h40 || bus.pwdata_o !== 32'h0) begin
            $display("FAIL rd_setup got rdy/sel/en/wr=%b addr=%h wdata=%h want 0100 40 0",
                     {bus.req_ready_o, bus.psel_o, bus.penable_o, bus.pwrite_o}, bus.paddr_o, bus.pwdata_o);
        end else passed++;
        // The APB inputs are active during SETUP and must be ignored there.
        bus.pready_i = 1'b1; bus.prdata_i = 32'hBAD0_BAD0; bus.pslverr_i = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 3'b110 || bus.paddr_o !== 32'h40) begin
            $display("FAIL rd_access got sel/en/vld=%b addr=%h want 110 40",
                     {bus.psel_o, bus.penable_o, bus.rsp_valid_o}, bus.paddr_o);
        end else passed++;
        bus.pready_i = 1'b1; bus.prdata_i = 32'hDEAD_BEEF; bus.pslverr_i = 1'b0;
        @(negedge clk);
        bus.pready_i = 1'b0; bus.prdata_i = 32'h0;
        total++;
        if ({bus.rsp_valid_o, bus.psel_o, bus.penable_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 5'b10000 ||
            bus.rsp_rdata_o !== 32'hDEAD_BEEF) begin
            $display("FAIL rd_resp got vld/sel/en/err/to=%b rdata=%h want 10000 deadbeef",
                     {bus.rsp_valid_o, bus.psel_o, bus.penable_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
        end else passed++;
        @(negedge clk);
        total++;
        if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin
            $display("FAIL rd_idle got rdy/vld=%b want 10", {bus.req_ready_o, bus.rsp_valid_o});
        end else passed++;
    endtask

    task automatic test_write_wait();
        int en_cnt = 0;
        int bad    = 0;
        send_req(32'h10, 32'h1234_5678, 1'b1);
        bus.pready_i = 1'b0; bus.prdata_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.penable_o === 1'b1 && bus.psel_o === 1'b1) en_cnt++;
            if (bus.paddr_o !== 32'h10 || bus.pwdata_o !== 32'h1234_5678 || bus.pwrite_o !== 1'b1) bad++;
            bus.pready_i = (k == 3);
        end
        total++;
        if (en_cnt != 4) $display("FAIL wr_penable_cycles got %0d want 4", en_cnt);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL wr_bus_stable got %0d unstable cycles want 0", bad);
        else passed++;
        @(negedge clk);
        bus.pready_i = 1'b0;
        total++;
        if ({bus.rsp_valid_o, bus.penable_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 4'b1000 ||
            bus.rsp_rdata_o !== 32'h0) begin
            $display("FAIL wr_resp got vld/en/err/to=%b rdata=%h want 1000 0",
                     {bus.rsp_valid_o, bus.penable_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_slverr();
        send_req(32'h80, 32'h0, 1'b0);
        @(negedge clk);
        bus.pready_i = 1'b1; bus.pslverr_i = 1'b1; bus.prdata_i = 32'h0000_0055;
        @(negedge clk);
        bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
        total++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b110 || bus.rsp_rdata_o !== 32'h55) begin
            $display("FAIL slverr got vld/err/to=%b rdata=%h want 110 55",
                     {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
        end else passed++;
        @(negedge clk);
    endtask

    // This task reads with pready held low. If late_ready is set, pready rises
    // in the 4th ACCESS cycle. Every wait is bounded at 10 cycles.
    task automatic test_timeout(input logic late_ready);
        int acc = 0;
        send_req(32'h20, 32'h0, 1'b0);
        bus.pready_i = 1'b0; bus.prdata_i = 32'hA5A5_A5A5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.penable_o !== 1'b1) break;
            acc++;
            if (late_ready && acc == 4) bus.pready_i = 1'b1;
        end
        bus.pready_i = 1'b0;
        total++;
        if (acc != 4) $display("FAIL timeout_cycles(late=%0b) got %0d want 4", late_ready, acc);
        else passed++;
        total++;
        if (late_ready) begin
            if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b100 || bus.rsp_rdata_o !== 32'hA5A5_A5A5) begin
                $display("FAIL timeout_late_ready got vld/err/to=%b rdata=%h want 100 a5a5a5a5",
                         {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
            end else passed++;
        end else begin
            if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b111 || bus.rsp_rdata_o !== 32'h0) begin
                $display("FAIL timeout_abort got vld/err/to=%b rdata=%h want 111 0",
                         {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
            end else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        send_req(32'h44, 32'h0, 1'b0);
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.pready_i = 1'b1; bus.prdata_i = 32'h0BAD_CAFE;
        @(negedge clk);
        bus.pready_i = 1'b0; bus.prdata_i = 32'h0;
        // A second request waits during the stall and must not be taken.
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h88; bus.req_write_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0BAD_CAFE || bus.req_ready_o !== 1'b0 ||
                bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0) bad++;
            if (i < 4) @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        else passed++;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.req_ready_o, bus.rsp_valid_o, bus.psel_o} !== 3'b100) begin
            $display("FAIL bp_release got rdy/vld/sel=%b want 100", {bus.req_ready_o, bus.rsp_valid_o, bus.psel_o});
        end else passed++;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        total++;
        if ({bus.psel_o, bus.penable_o} !== 2'b10 || bus.paddr_o !== 32'h88) begin
            $display("FAIL bp_next_req got sel/en=%b addr=%h want 10 88", {bus.psel_o, bus.penable_o}, bus.paddr_o);
        end else passed++;
        // Finish the second request with zero wait.
        @(negedge clk);
        bus.pready_i = 1'b1;
        @(negedge clk);
        bus.pready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_access();
        send_req(32'h60, 32'h0, 1'b0);
        bus.pready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 3'b000) begin
            $display("FAIL rst_access got sel/en/vld=%b want 000", {bus.psel_o, bus.penable_o, bus.rsp_valid_o});
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin
            $display("FAIL rst_after got rdy/vld=%b want 10", {bus.req_ready_o, bus.rsp_valid_o});
        end else passed++;
        send_req(32'h64, 32'h0, 1'b0);
        @(negedge clk);
        bus.pready_i = 1'b1; bus.prdata_i = 32'h1357_9BDF;
        @(negedge clk);
        bus.pready_i = 1'b0;
        total++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b100 || bus.rsp_rdata_o !== 32'h1357_9BDF) begin
            $display("FAIL rst_followup got vld/err/to=%b rdata=%h want 100 13579bdf",
                     {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, bus.rsp_rdata_o);
        end else passed++;
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_write_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slverr();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_reset_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
